// File: rtl/matrix_load_64_if.sv
// Row-stream in / assembled-matrix out bundle for matrix_load_64.
// master: the row producer (drives en, in_valid, in_row; observes status and Matrix).
// slave : matrix_load_64 itself.
interface matrix_load_64_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIM    = 64
);
    localparam int unsigned ROW_W = DIM * DATA_W;
    localparam int unsigned MAT_W = DIM * DIM * DATA_W;
    localparam int unsigned CNT_W = $clog2(DIM);

    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_row;
    logic [MAT_W-1:0] Matrix;
    logic [CNT_W-1:0] row_cnt;
    logic             busy;
    logic             finish;

    modport master (
        output en, in_valid, in_row,
        input  in_ready, Matrix, row_cnt, busy, finish
    );

    modport slave (
        input  en, in_valid, in_row,
        output in_ready, Matrix, row_cnt, busy, finish
    );
endinterface

// File: rtl/matrix_load_64.sv
// matrix_load_64: assembles a DIM x DIM signed matrix from one row per handshake
// beat and holds it, with finish high, for the downstream tile selector.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (zeroes Matrix)
//   bus (slave)  en start pulse, in_valid/in_ready/in_row row stream,
//                Matrix flat output, row_cnt beats taken, busy, finish
// Build option: MATRIX_LOAD_TRANSPOSE_EN writes beat k as column k instead of row k.
module matrix_load_64 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIM    = 64
) (
    input logic             clk,
    input logic             rst,
    matrix_load_64_if.slave bus
);
    localparam int unsigned ROW_W = DIM * DATA_W;
    localparam int unsigned MAT_W = DIM * DIM * DATA_W;
    localparam int unsigned CNT_W = $clog2(DIM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
    logic               finish_q, finish_d;
    logic               accept_c;
    logic [MAT_W-1:0]   matrix_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        finish_d  = finish_q;
        accept_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d   = LOAD;
                    row_cnt_d = '0;
                end
            end
            LOAD: begin
                if (bus.in_valid) begin
                    accept_c  = 1'b1;
                    row_cnt_d = row_cnt_q + CNT_W'(1);
                    if (row_cnt_q == CNT_W'(DIM - 1)) begin
                        state_d   = DONE;
                        finish_d  = 1'b1;
                        row_cnt_d = '0;
                    end
                end
            end
            DONE: begin
                if (bus.en) begin
                    state_d   = LOAD;
                    finish_d  = 1'b0;
                    row_cnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                row_cnt_d = '0;
                finish_d  = 1'b0;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            finish_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            finish_q  <= finish_d;
        end
    end

    // Matrix storage: only the addressed row (or column) is written per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            matrix_q <= '0;
        end else if (accept_c) begin
`ifdef MATRIX_LOAD_TRANSPOSE_EN
            for (int unsigned c = 0; c < DIM; c++) begin
                matrix_q[(c * DIM + 32'(row_cnt_q)) * DATA_W +: DATA_W]
                    <= bus.in_row[c * DATA_W +: DATA_W];
            end
`else
            matrix_q[32'(row_cnt_q) * ROW_W +: ROW_W] <= bus.in_row;
`endif
        end
    end

    // Handshake status comes from the state register alone.
    assign bus.in_ready = (state_q == LOAD);
    assign bus.busy     = (state_q == LOAD);
    assign bus.Matrix   = matrix_q;
    assign bus.row_cnt  = row_cnt_q;
    assign bus.finish   = finish_q;
endmodule

// File: tb/tb_matrix_load_64.sv
// Self-checking bench for matrix_load_64: a short vector table plus directed
// load sequences, all checked against a behavioural matrix model.
module tb_matrix_load_64;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIM    = 64;
    localparam int unsigned ROW_W  = DIM * DATA_W;

    logic clk;
    logic rst;

    matrix_load_64_if #(.DATA_W(DATA_W), .DIM(DIM)) bus ();

    matrix_load_64 #(.DATA_W(DATA_W), .DIM(DIM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: phase 0 = waiting for first start, 1 = loading, 2 = holding.
    logic [DATA_W-1:0] m_mat [DIM][DIM];
    int                m_phase;
    int                m_cnt;
    bit                m_fin;

    typedef struct {
        logic       en;
        logic       valid;
        logic [5:0] exp_cnt;
        logic       exp_fin;
        logic       exp_rdy;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_matrix(input string name);
        int bad_r, bad_c;
        logic [DATA_W-1:0] got, want;
        bad_r = -1;
        bad_c = -1;
        got = '0;
        want = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                if (bad_r < 0 && bus.Matrix[(r * DIM + c) * DATA_W +: DATA_W] !== m_mat[r][c]) begin
                    bad_r = r;
                    bad_c = c;
                    got   = bus.Matrix[(r * DIM + c) * DATA_W +: DATA_W];
                    want  = m_mat[r][c];
                end
        checks++;
        if (bad_r >= 0) begin
            failures++;
            $display("FAIL %s: element (%0d,%0d) got %h expected %h (t=%0t)",
                     name, bad_r, bad_c, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        m_fin   = 1'b0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                m_mat[r][c] = '0;
    endtask

    // Apply one clock edge of the behaviour described for the block.
    task automatic model_edge(input logic e, input logic v, input logic [ROW_W-1:0] row);
        if (m_phase == 1) begin
            if (v) begin
                for (int c = 0; c < DIM; c++) begin
`ifdef MATRIX_LOAD_TRANSPOSE_EN
                    m_mat[c][m_cnt] = row[c * DATA_W +: DATA_W];
`else
                    m_mat[m_cnt][c] = row[c * DATA_W +: DATA_W];
`endif
                end
                if (m_cnt == DIM - 1) begin
                    m_phase = 2;
                    m_fin   = 1'b1;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
        end else if (e) begin
            m_phase = 1;
            m_cnt   = 0;
            m_fin   = 1'b0;
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".row_cnt"},  longint'(bus.row_cnt),  longint'(m_cnt));
        chk({tag, ".finish"},   longint'(bus.finish),   longint'(m_fin));
        chk({tag, ".in_ready"}, longint'(bus.in_ready), longint'(m_phase == 1));
        chk({tag, ".busy"},     longint'(bus.busy),     longint'(m_phase == 1));
        chk_matrix({tag, ".Matrix"});
    endtask

    task automatic step(input logic e, input logic v, input logic [ROW_W-1:0] row,
                        input string tag);
        bus.en       = e;
        bus.in_valid = v;
        bus.in_row   = row;
        @(posedge clk);
        model_edge(e, v, row);
        cyc++;
        #1;
        chk_outputs(tag);
    endtask

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < int'(ROW_W / 32); i++)
            r[i * 32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] idx_row(input int k);
        logic [ROW_W-1:0] r;
        for (int c = 0; c < DIM; c++)
            r[c * DATA_W +: DATA_W] = DATA_W'(k * DIM + c);
        return r;
    endfunction

    // mode 0: index pattern, 1: index pattern with stalls, 2: all -1, 3: random.
    task automatic load_matrix(input int mode, input string tag, output int cycles);
        int start, beat, stall, n;
        logic v, e;
        logic [ROW_W-1:0] row;
        step(1'b1, 1'b0, '0, {tag, ".start"});
        start = cyc;
        beat  = 0;
        stall = 0;
        n     = 0;
        while (m_phase == 1 && n < 400) begin
            e = 1'b0;
            if (mode == 1 && stall > 0) begin
                v = 1'b0;
                stall--;
            end else if (mode == 3) begin
                v = ($urandom_range(0, 3) != 0);
                e = ($urandom_range(0, 4) == 0) || (beat == 10) || (beat == DIM - 1);
            end else begin
                v = 1'b1;
            end
            case (mode)
                2:       row = '1;
                3:       row = rand_row();
                default: row = idx_row(beat);
            endcase
            if (mode == 3 && beat == 5) row[DATA_W-1:0] = 16'h8000;
            step(e, v, row, tag);
            if (v) begin
                if (mode == 1 && (beat == 0 || beat == 31 || beat == 62)) stall = 3;
                beat++;
            end
            n++;
        end
        chk({tag, ".completed"}, longint'(m_phase), 2);
        cycles = cyc - start;
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        chk_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs [8];
    int   cyc_cont, cyc_stall, cyc_tmp;

    initial begin
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
        model_reset();
        #1;
        chk_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Short handshake table straight out of reset.
        vecs[0] = '{en: 1'b0, valid: 1'b1, exp_cnt: 6'd0, exp_fin: 1'b0, exp_rdy: 1'b0};
        vecs[1] = '{en: 1'b1, valid: 1'b1, exp_cnt: 6'd0, exp_fin: 1'b0, exp_rdy: 1'b1};
        vecs[2] = '{en: 1'b0, valid: 1'b1, exp_cnt: 6'd1, exp_fin: 1'b0, exp_rdy: 1'b1};
        vecs[3] = '{en: 1'b0, valid: 1'b0, exp_cnt: 6'd1, exp_fin: 1'b0, exp_rdy: 1'b1};
        vecs[4] = '{en: 1'b1, valid: 1'b1, exp_cnt: 6'd2, exp_fin: 1'b0, exp_rdy: 1'b1};
        vecs[5] = '{en: 1'b0, valid: 1'b1, exp_cnt: 6'd3, exp_fin: 1'b0, exp_rdy: 1'b1};
        vecs[6] = '{en: 1'b1, valid: 1'b0, exp_cnt: 6'd3, exp_fin: 1'b0, exp_rdy: 1'b1};
        vecs[7] = '{en: 1'b0, valid: 1'b1, exp_cnt: 6'd4, exp_fin: 1'b0, exp_rdy: 1'b1};
        for (int i = 0; i < 8; i++) begin
            step(vecs[i].en, vecs[i].valid, rand_row(), "table");
            chk("table.cnt", longint'(bus.row_cnt),  longint'(vecs[i].exp_cnt));
            chk("table.fin", longint'(bus.finish),   longint'(vecs[i].exp_fin));
            chk("table.rdy", longint'(bus.in_ready), longint'(vecs[i].exp_rdy));
        end

        // Continuous index-pattern load from a clean matrix.
        async_reset("rst_cont");
        load_matrix(0, "cont", cyc_cont);
        chk("cont.cycles", cyc_cont, 64);
        chk("cont.ready_done", longint'(bus.in_ready), 0);
        chk("cont.elem_63_63", longint'(bus.Matrix[(63 * DIM + 63) * DATA_W +: DATA_W]), 4095);
        step(1'b0, 1'b1, rand_row(), "done_hold");
        step(1'b0, 1'b1, rand_row(), "done_hold");

        // Same load with three 3-cycle stalls.
        async_reset("rst_stall");
        load_matrix(1, "stall", cyc_stall);
        chk("stall.delay", cyc_stall - cyc_cont, 9);

        // Reload over the held matrix with all-ones rows.
        load_matrix(2, "reload", cyc_tmp);
        chk("reload.cycles", cyc_tmp, 64);
        chk("reload.elem_0_0", longint'(bus.Matrix[DATA_W-1:0]), longint'(16'hFFFF));

        // Random load with stray enables, 0x8000 in row 5 and en on the last beat.
        load_matrix(3, "random", cyc_tmp);
`ifdef MATRIX_LOAD_TRANSPOSE_EN
        chk("random.elem_8000", longint'(bus.Matrix[5 * DATA_W +: DATA_W]), longint'(16'h8000));
`else
        chk("random.elem_8000", longint'(bus.Matrix[5 * DIM * DATA_W +: DATA_W]), longint'(16'h8000));
`endif
        step(1'b0, 1'b0, '0, "random.after");
        load_matrix(3, "random2", cyc_tmp);

        // Reset between edges after 20 beats of a load.
        step(1'b1, 1'b0, '0, "midrst.start");
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, rand_row(), "midrst.beat");
        #3;
        async_reset("midrst");
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, rand_row(), "midrst.idle");
        step(1'b1, 1'b0, '0, "midrst.restart");
        chk("midrst.ready_after_en", longint'(bus.in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
